// File: rtl/local_irq_ctrl_pkg.sv
// Shared types and helpers for the local interrupt controller.
// LOCAL_IRQ_PRIO_EN selects programmable priorities in local_irq_ctrl.
package local_irq_ctrl_pkg;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_ACTIVE} irq_state_e;

  localparam logic [1:0] MTVEC_MODE_VEC = 2'b01;

  // Trap target for a given mtvec and cause code; vectored mode offsets by 4 bytes per code.
  function automatic logic [31:0] irq_handler(input logic [31:0] vec, input logic [31:0] code);
    logic [31:0] base;
    base = {vec[31:2], 2'b00};
    return (vec[1:0] == MTVEC_MODE_VEC) ? base + (code << 2) : base;
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner select: highest priority among candidates, ties to the lowest index.
module irq_prio_sel
  import local_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0]   cand_i,
  input  logic [NUM_SRC*3-1:0] prio_i,
  output logic                 valid_o,
  output logic [4:0]           id_o
);

  logic [2:0] best;

  // Scanning downwards with >= lets a lower index win a tie.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    best    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_i[i] && (!valid_o || prio_i[i*3 +: 3] >= best)) begin
        valid_o = 1'b1;
        id_o    = 5'(i);
        best    = prio_i[i*3 +: 3];
      end
    end
  end

endmodule

// File: rtl/local_irq_ctrl.sv
// N-source local interrupt controller with registered request and take/return handshake.
// Define LOCAL_IRQ_PRIO_EN for per-source priorities and a threshold; default is index priority.
module local_irq_ctrl
  import local_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 16,
  parameter int unsigned CAUSE_BASE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic [NUM_SRC-1:0]   ie_i,
  input  logic [NUM_SRC-1:0]   edge_i,
  input  logic                 mie_i,
  input  logic [31:0]          vec_i,
  input  logic [31:0]          pc_i,
  input  logic                 take_i,
  input  logic                 mret_i,
`ifdef LOCAL_IRQ_PRIO_EN
  input  logic [NUM_SRC*3-1:0] prio_i,
  input  logic [2:0]           threshold_i,
`endif
  output logic                 irq_valid_o,
  output logic [31:0]          handler_o,
  output logic [31:0]          cause_o,
  output logic [31:0]          epc_o,
  output logic [4:0]           id_o,
  output logic [NUM_SRC-1:0]   pending_o
);

  logic [NUM_SRC-1:0] src_s, prev_q, prev_d, epend_q, epend_d, clr, pending, elig, cand;
  logic [NUM_SRC*3-1:0] prio_s;
  irq_state_e           state_q, state_d;
  logic [31:0]          handler_q, handler_d, cause_q, cause_d, epc_q, epc_d;
  logic [4:0]           id_q, id_d, win_id;
  logic [30:0]          win_code;
  logic                 win_valid, take_fire;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign src_s = src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
    always_comb begin
      sync_d[0] = src_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_d[s] = sync_q[s-1];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= sync_d;
    end
    assign src_s = sync_q[SYNC_STAGES-1];
  end

  // Edge pending latches rising edges; the taken source's bit clears and wins over a new edge.
  always_comb begin
    prev_d = src_s;
    for (int i = 0; i < int'(NUM_SRC); i++) clr[i] = take_fire && (id_q == 5'(i));
    epend_d = (epend_q | (src_s & ~prev_q)) & edge_i & ~clr;
  end

  assign pending = (edge_i & epend_q) | (~edge_i & src_s);

`ifdef LOCAL_IRQ_PRIO_EN
  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) elig[i] = prio_i[i*3 +: 3] > threshold_i;
  end
  assign prio_s = prio_i;
`else
  assign elig   = '1;
  assign prio_s = '1;
`endif

  assign cand = pending & ie_i & elig;

  irq_prio_sel #(
    .NUM_SRC(NUM_SRC)
  ) u_prio_sel (
    .cand_i (cand),
    .prio_i (prio_s),
    .valid_o(win_valid),
    .id_o   (win_id)
  );

  assign win_code = 31'(CAUSE_BASE) + 31'(win_id);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cause_d   = cause_q;
    handler_d = handler_q;
    epc_d     = epc_q;
    take_fire = 1'b0;
    unique case (state_q)
      IRQ_IDLE: begin
        if (win_valid && mie_i) begin
          state_d   = IRQ_REQ;
          id_d      = win_id;
          cause_d   = {1'b1, win_code};
          handler_d = irq_handler(vec_i, {1'b0, win_code});
        end
      end
      IRQ_REQ: begin
        if (take_i) begin
          state_d   = IRQ_ACTIVE;
          epc_d     = pc_i;
          take_fire = 1'b1;
        end else if (!win_valid || !mie_i) begin
          state_d = IRQ_IDLE;
        end else begin
          id_d      = win_id;
          cause_d   = {1'b1, win_code};
          handler_d = irq_handler(vec_i, {1'b0, win_code});
        end
      end
      IRQ_ACTIVE: begin
        if (mret_i) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IRQ_IDLE;
      prev_q    <= '0;
      epend_q   <= '0;
      id_q      <= '0;
      cause_q   <= '0;
      handler_q <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      epend_q   <= epend_d;
      id_q      <= id_d;
      cause_q   <= cause_d;
      handler_q <= handler_d;
      epc_q     <= epc_d;
    end
  end

  assign irq_valid_o = (state_q == IRQ_REQ);
  assign handler_o   = handler_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign id_o        = id_q;
  assign pending_o   = pending;

endmodule

// File: tb/tb_local_irq_ctrl.sv
// Scoreboard bench for local_irq_ctrl (NUM_SRC=16, CAUSE_BASE=16, SYNC_STAGES=2).
module tb_local_irq_ctrl;

  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src, ie, edg;
  logic          mie, take, mret;
  logic [31:0]   vec, pc;
  logic          irq_valid_o;
  logic [31:0]   handler_o, cause_o, epc_o;
  logic [4:0]    id_o;
  logic [N-1:0]  pending_o;
`ifdef LOCAL_IRQ_PRIO_EN
  logic [N*3-1:0] prio;
  logic [2:0]     thr;
`endif

  typedef struct {
    logic [4:0]  id;
    logic [31:0] cause;
    logic [31:0] handler;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  local_irq_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src),
    .ie_i       (ie),
    .edge_i     (edg),
    .mie_i      (mie),
    .vec_i      (vec),
    .pc_i       (pc),
    .take_i     (take),
    .mret_i     (mret),
`ifdef LOCAL_IRQ_PRIO_EN
    .prio_i     (prio),
    .threshold_i(thr),
`endif
    .irq_valid_o(irq_valid_o),
    .handler_o  (handler_o),
    .cause_o    (cause_o),
    .epc_o      (epc_o),
    .id_o       (id_o),
    .pending_o  (pending_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Reference model for the registered request fields.
  task automatic push_exp(input int id, input logic [31:0] v);
    exp_t e;
    logic [31:0] code;
    code      = 32'd16 + 32'(id);
    e.id      = 5'(id);
    e.cause   = 32'h8000_0000 | code;
    e.handler = {v[31:2], 2'b00} + ((v[1:0] == 2'b01) ? code * 4 : 32'd0);
    sb.push_back(e);
  endtask

  task automatic expect_req(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c < 20 && !seen; c++) begin
      if (irq_valid_o && id_o == e.id) seen = 1'b1;
      else tick();
    end
    check({tag, "_valid"}, {31'd0, seen}, 32'd1);
    check({tag, "_id"}, 32'(id_o), 32'(e.id));
    check({tag, "_cause"}, cause_o, e.cause);
    check({tag, "_handler"}, handler_o, e.handler);
  endtask

  task automatic do_take(input logic [31:0] p);
    pc   = p;
    take = 1'b1;
    tick();
    take = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; ie = '0; edg = '0; mie = 1'b0; take = 1'b0; mret = 1'b0;
    vec = '0; pc = '0;
`ifdef LOCAL_IRQ_PRIO_EN
    prio = '0; thr = '0;
`endif
    ticks(3);
    check("rst_valid", {31'd0, irq_valid_o}, 32'd0);
    check("rst_cause", cause_o, 32'd0);
    check("rst_handler", handler_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_id", 32'(id_o), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    rst = 1'b0;
    tick();

`ifndef LOCAL_IRQ_PRIO_EN
    // Level source 3: two sync stages, then the request one cycle after pending.
    ie = 16'h0008; mie = 1'b1; src[3] = 1'b1;
    push_exp(3, vec);
    ticks(2);
    check("t1_pend", 32'(pending_o), 32'h0008);
    check("t1_not_yet", {31'd0, irq_valid_o}, 32'd0);
    tick();
    check("t1_latency", {31'd0, irq_valid_o}, 32'd1);
    expect_req("t1");
    do_take(32'h0000_1234);
    check("t1_epc", epc_o, 32'h0000_1234);
    check("t1_valid_off", {31'd0, irq_valid_o}, 32'd0);
    src[3] = 1'b0;
    ticks(4);
    do_mret();
    ticks(2);
    check("t1_idle", {31'd0, irq_valid_o}, 32'd0);

    // Edge source 5 pulse, take clears pending, ACTIVE blocks a new level request.
    edg = 16'h0020; ie = 16'h0028;
    src[5] = 1'b1; tick(); src[5] = 1'b0;
    push_exp(5, vec);
    expect_req("t2");
    check("t2_pend_set", 32'(pending_o[5]), 32'd1);
    do_take(32'h0000_2000);
    check("t2_pend_clr", 32'(pending_o), 32'd0);
    check("t2_epc", epc_o, 32'h0000_2000);
    src[3] = 1'b1;
    ticks(5);
    check("t2_active_block", {31'd0, irq_valid_o}, 32'd0);
    push_exp(3, vec);
    do_mret();
    expect_req("t2_after_mret");
    do_take(32'h0000_2004);
    src[3] = 1'b0;
    ticks(4);
    do_mret();

    // Sources 2 and 7; removing 2 hands the request to 7.
    edg = '0; ie = 16'h0084; src = 16'h0084;
    push_exp(2, vec);
    expect_req("t3_first");
    src[2] = 1'b0;
    push_exp(7, vec);
    expect_req("t3_switch");
    do_take(32'h0000_3000);
    src = '0;
    ticks(4);
    do_mret();

    // Vectored then direct handler for source 0.
    vec = 32'h1000_0001; ie = 16'h0001; src[0] = 1'b1;
    push_exp(0, vec);
    expect_req("t4_vec");
    vec = 32'h1000_0000;
    tick();
    push_exp(0, vec);
    expect_req("t4_direct");
    src[0] = 1'b0;
    ticks(4);
    check("t4_withdrawn", {31'd0, irq_valid_o}, 32'd0);
    check("t4_handler_hold", handler_o, 32'h1000_0000);

    // mie drop withdraws; edge pending survives; request returns with mie.
    edg = 16'h0200; ie = 16'h0200;
    src[9] = 1'b1; tick(); src[9] = 1'b0;
    push_exp(9, vec);
    expect_req("t5_first");
    mie = 1'b0;
    tick();
    check("t5_withdraw", {31'd0, irq_valid_o}, 32'd0);
    ticks(3);
    check("t5_pend_kept", 32'(pending_o[9]), 32'd1);
    mie = 1'b1;
    push_exp(9, vec);
    expect_req("t5_return");
    do_take(32'h0000_5000);
    check("t5_pend_clr", 32'(pending_o), 32'd0);
    do_mret();
`else
    // Programmable priority with threshold.
    ie = 16'h0012; mie = 1'b1;
    prio[1*3 +: 3] = 3'd2; prio[4*3 +: 3] = 3'd6; thr = 3'd5;
    src = 16'h0012;
    push_exp(4, vec);
    expect_req("t6_prio");
    thr = 3'd6;
    ticks(2);
    check("t6_thr_block", {31'd0, irq_valid_o}, 32'd0);
    src = '0;
    thr = 3'd0;
    ticks(4);
`endif

    // Reset during service: asynchronous clear of everything.
    edg = 16'h0001; ie = 16'h0001; mie = 1'b1;
    src[0] = 1'b1; tick(); src[0] = 1'b0;
    push_exp(0, vec);
    expect_req("t7");
    do_take(32'h0000_7000);
    check("t7_epc", epc_o, 32'h0000_7000);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_epc", epc_o, 32'd0);
    check("t7_rst_valid", {31'd0, irq_valid_o}, 32'd0);
    check("t7_rst_cause", cause_o, 32'd0);
    tick();
    rst = 1'b0;
    ticks(4);
    check("t7_idle", {31'd0, irq_valid_o}, 32'd0);
    check("t7_pend", 32'(pending_o), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
